reaction_timer: RTL and testbench

//  Human reaction-time tester for a 50 MHz TinyTapeout tile. A button press arms a

---
 rtl/reaction_timer_if.sv | 28 ++
 rtl/reaction_timer.sv | 270 +++++++++++++++++++++++++++
 tb/tb_reaction_timer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reaction_timer_if.sv
// Player/LCD-facing signals of reaction_timer: button in, go light, result bus and
// HD44780 8-bit parallel LCD pins out.
interface reaction_timer_if;
  logic        button;
  logic        led;
  logic [15:0] reaction_time;
  logic [7:0]  lcd_data;
  logic        lcd_rs;
  logic        lcd_en;

  modport master (
    output button,
    input  led,
    input  reaction_time,
    input  lcd_data,
    input  lcd_rs,
    input  lcd_en
  );

  modport slave (
    input  button,
    output led,
    output reaction_time,
    output lcd_data,
    output lcd_rs,
    output lcd_en
  );
endinterface

// File: rtl/reaction_timer.sv
// Reaction-time tester: press arms a random delay, LED lights, ms counted until next press.
// Define REACTION_LCD_EN to build the HD44780 sequencer that prints each result.
module reaction_timer #(
  parameter int unsigned TICK_CYCLES = 50000,
  parameter int unsigned MIN_DELAY   = 500,
  parameter int unsigned RAND_MASK   = 1023,
  parameter int unsigned MAX_MS      = 9999,
  parameter int unsigned LCD_WAIT    = 2500,
  parameter int unsigned LCD_EN_HI   = 25
) (
  input logic             clk,
  input logic             reset,
  reaction_timer_if.slave bus
);
  localparam int unsigned DivW = $clog2(TICK_CYCLES + 1);
  localparam int unsigned DlyW = $clog2(MIN_DELAY + RAND_MASK + 1);

  typedef enum logic [1:0] {StIdle, StWait, StArmed, StDone} state_e;

  state_e          state_q, state_d;
  logic            btn_s1_q, btn_s2_q, btn_prev_q;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [DivW-1:0] div_q, div_d;
  logic [DlyW-1:0] delay_q, delay_d;
  logic [15:0]     ms_q, ms_d;
  logic [15:0]     rt_q, rt_d;
  logic            led_q, led_d;
  logic            press, tick;

  assign press = btn_s2_q & ~btn_prev_q;
  assign tick  = (div_q == DivW'(TICK_CYCLES - 1));

  always_comb begin
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    div_d   = tick ? '0 : div_q + DivW'(1);
    state_d = state_q;
    delay_d = delay_q;
    ms_d    = ms_q;
    rt_d    = rt_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (press) begin
          state_d = StWait;
          delay_d = DlyW'(MIN_DELAY) + DlyW'(lfsr_q & 16'(RAND_MASK));
        end
      end
      StWait: begin
        // A press wins over a coincident expiry: that is still a false start.
        if (press) begin
          state_d = StDone;
          rt_d    = 16'hFFFF;
        end else if (delay_q == '0) begin
          state_d = StArmed;
          ms_d    = '0;
          div_d   = '0;
        end else if (tick) begin
          delay_d = delay_q - DlyW'(1);
        end
      end
      StArmed: begin
        if (press) begin
          state_d = StDone;
          rt_d    = ms_q;
        end else if (ms_q == 16'(MAX_MS)) begin
          state_d = StDone;
          rt_d    = 16'(MAX_MS);
        end else if (tick) begin
          ms_d = ms_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    led_d = (state_d == StArmed);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      btn_s1_q   <= 1'b0;
      btn_s2_q   <= 1'b0;
      btn_prev_q <= 1'b0;
      lfsr_q     <= 16'hACE1;
      div_q      <= '0;
      delay_q    <= '0;
      ms_q       <= '0;
      rt_q       <= '0;
      led_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_s1_q   <= bus.button;
      btn_s2_q   <= btn_s1_q;
      btn_prev_q <= btn_s2_q;
      lfsr_q     <= lfsr_d;
      div_q      <= div_d;
      delay_q    <= delay_d;
      ms_q       <= ms_d;
      rt_q       <= rt_d;
      led_q      <= led_d;
    end
  end

  assign bus.led           = led_q;
  assign bus.reaction_time = rt_q;

`ifdef REACTION_LCD_EN
  typedef enum logic [2:0] {LcIdle, LcBcd, LcLoad, LcSetup, LcEnHi, LcWait} lcd_state_e;

  lcd_state_e      lc_state_q, lc_state_d;
  logic            lc_init_q, lc_init_d, lc_pend_q, lc_pend_d, lc_err_q, lc_err_d;
  logic [2:0]      lc_idx_q, lc_idx_d;
  logic [1:0]      lc_pos_q, lc_pos_d;
  logic [15:0]     lc_bin_q, lc_bin_d;
  logic [3:0][3:0] lc_dig_q, lc_dig_d;
  logic [31:0]     lc_cnt_q, lc_cnt_d;
  logic [7:0]      lcd_data_q, lcd_data_d;
  logic            lcd_rs_q, lcd_rs_d, lcd_en_q, lcd_en_d;
  logic [7:0]      lc_byte;
  logic            lc_byte_rs, lc_last, done_entry;
  logic [15:0]     lc_step;

  assign done_entry = (state_d == StDone) && (state_q != StDone);
  assign lc_last    = lc_init_q ? (lc_idx_q == 3'd3) : (lc_idx_q == 3'd4);

  // Byte 0 of an update is the DDRAM home command; bytes 1..4 are thousands..units.
  always_comb begin
    lc_byte    = 8'h80;
    lc_byte_rs = 1'b0;
    if (lc_init_q) begin
      unique case (lc_idx_q[1:0])
        2'd0:    lc_byte = 8'h38;
        2'd1:    lc_byte = 8'h0C;
        2'd2:    lc_byte = 8'h01;
        default: lc_byte = 8'h06;
      endcase
    end else if (lc_idx_q != 3'd0) begin
      lc_byte_rs = 1'b1;
      if (lc_err_q) begin
        unique case (lc_idx_q)
          3'd1:       lc_byte = 8'h45;
          3'd2, 3'd3: lc_byte = 8'h72;
          default:    lc_byte = 8'h21;
        endcase
      end else begin
        lc_byte = {4'h3, lc_dig_q[2'(3'd4 - lc_idx_q)]};
      end
    end
  end

  always_comb begin
    unique case (lc_pos_q)
      2'd3:    lc_step = 16'd1000;
      2'd2:    lc_step = 16'd100;
      2'd1:    lc_step = 16'd10;
      default: lc_step = 16'd1;
    endcase
  end

  always_comb begin
    lc_state_d = lc_state_q;
    lc_init_d  = lc_init_q;
    lc_pend_d  = lc_pend_q | done_entry;
    lc_err_d   = lc_err_q;
    lc_idx_d   = lc_idx_q;
    lc_pos_d   = lc_pos_q;
    lc_bin_d   = lc_bin_q;
    lc_dig_d   = lc_dig_q;
    lc_cnt_d   = lc_cnt_q;
    lcd_data_d = lcd_data_q;
    lcd_rs_d   = lcd_rs_q;
    lcd_en_d   = lcd_en_q;
    unique case (lc_state_q)
      LcIdle: begin
        if (lc_init_q) begin
          lc_state_d = LcLoad;
        end else if (lc_pend_q) begin
          lc_pend_d  = done_entry;
          lc_bin_d   = rt_q;
          lc_err_d   = (rt_q == 16'hFFFF);
          lc_dig_d   = '0;
          lc_pos_d   = 2'd3;
          lc_idx_d   = 3'd0;
          lc_state_d = (rt_q == 16'hFFFF) ? LcLoad : LcBcd;
        end
      end
      LcBcd: begin
        // Repeated subtraction, one step per clock.
        if (lc_bin_q >= lc_step) begin
          lc_bin_d           = lc_bin_q - lc_step;
          lc_dig_d[lc_pos_q] = lc_dig_q[lc_pos_q] + 4'd1;
        end else if (lc_pos_q == 2'd0) begin
          lc_state_d = LcLoad;
        end else begin
          lc_pos_d = lc_pos_q - 2'd1;
        end
      end
      LcLoad: begin
        lcd_data_d = lc_byte;
        lcd_rs_d   = lc_byte_rs;
        lc_state_d = LcSetup;
      end
      LcSetup: begin
        lcd_en_d   = 1'b1;
        lc_cnt_d   = 32'(LCD_EN_HI - 1);
        lc_state_d = LcEnHi;
      end
      LcEnHi: begin
        if (lc_cnt_q == '0) begin
          lcd_en_d   = 1'b0;
          // Clear-display needs a much longer settle time.
          lc_cnt_d   = (lc_init_q && lc_idx_q == 3'd2) ? 32'(40 * LCD_WAIT - 1)
                                                      : 32'(LCD_WAIT - 1);
          lc_state_d = LcWait;
        end else begin
          lc_cnt_d = lc_cnt_q - 32'd1;
        end
      end
      LcWait: begin
        if (lc_cnt_q != '0) begin
          lc_cnt_d = lc_cnt_q - 32'd1;
        end else if (lc_last) begin
          lc_init_d  = 1'b0;
          lc_state_d = LcIdle;
        end else begin
          lc_idx_d   = lc_idx_q + 3'd1;
          lc_state_d = LcLoad;
        end
      end
      default: lc_state_d = LcIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lc_state_q <= LcIdle;
      lc_init_q  <= 1'b1;
      lc_pend_q  <= 1'b0;
      lc_err_q   <= 1'b0;
      lc_idx_q   <= '0;
      lc_pos_q   <= '0;
      lc_bin_q   <= '0;
      lc_dig_q   <= '0;
      lc_cnt_q   <= '0;
      lcd_data_q <= '0;
      lcd_rs_q   <= 1'b0;
      lcd_en_q   <= 1'b0;
    end else begin
      lc_state_q <= lc_state_d;
      lc_init_q  <= lc_init_d;
      lc_pend_q  <= lc_pend_d;
      lc_err_q   <= lc_err_d;
      lc_idx_q   <= lc_idx_d;
      lc_pos_q   <= lc_pos_d;
      lc_bin_q   <= lc_bin_d;
      lc_dig_q   <= lc_dig_d;
      lc_cnt_q   <= lc_cnt_d;
      lcd_data_q <= lcd_data_d;
      lcd_rs_q   <= lcd_rs_d;
      lcd_en_q   <= lcd_en_d;
    end
  end

  assign bus.lcd_data = lcd_data_q;
  assign bus.lcd_rs   = lcd_rs_q;
  assign bus.lcd_en   = lcd_en_q;
`else
  assign bus.lcd_data = '0;
  assign bus.lcd_rs   = 1'b0;
  assign bus.lcd_en   = 1'b0;
`endif
endmodule

// File: tb/tb_reaction_timer.sv
// Bench for reaction_timer: random reaction times checked against an elapsed-whole-ms
// model, plus false start, timeout, held button, async reset and (optional) LCD text.
module tb_reaction_timer;
  localparam int unsigned Tick    = 10;
  localparam int unsigned MinD    = 5;
  localparam int unsigned Mask    = 7;
  localparam int unsigned MaxMs   = 150;
  localparam int unsigned LcdWait = 20;
  localparam int unsigned LcdEnHi = 4;
  localparam int unsigned DlyLo   = (MinD - 1) * Tick;
  localparam int unsigned DlyHi   = (MinD + Mask) * Tick + 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic [8:0] strobes[$];

  reaction_timer_if bus ();

  reaction_timer #(
    .TICK_CYCLES(Tick),
    .MIN_DELAY  (MinD),
    .RAND_MASK  (Mask),
    .MAX_MS     (MaxMs),
    .LCD_WAIT   (LcdWait),
    .LCD_EN_HI  (LcdEnHi)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // LCD latches on the falling edge of lcd_en; record {rs, data} at each one.
  always @(negedge bus.lcd_en) if (reset) strobes.push_back({bus.lcd_rs, bus.lcd_data});

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Press lands in the FSM three edges after the button rises (2 sync flops + edge detect).
  task automatic press_btn();
    repeat (2) @(posedge clk);
    #1 bus.button = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.button = 1'b0;
  endtask

  task automatic wait_led(output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    while (cycles < int'(DlyHi + 200)) begin
      @(negedge clk);
      if (bus.led === 1'b1) begin
        ok = 1'b1;
        break;
      end
      cycles++;
    end
  endtask

  // Player presses so that the FSM sees it k edges after the light came on; the model
  // result is the number of whole ms ticks completed before that edge.
  task automatic run_reaction(input int unsigned k);
    int c;
    bit ok;
    logic [15:0] exp;
    press_btn();
    wait_led(c, ok);
    tests++;
    if (!ok || c < int'(DlyLo) || c > int'(DlyHi)) begin
      fails++;
      $display("FAIL random_delay: got %0d cycles (lit=%0d), required %0d..%0d", c, ok,
               DlyLo, DlyHi);
    end
    if (ok) begin
      repeat (k - 3) @(posedge clk);
      #1 bus.button = 1'b1;
      repeat (3) @(posedge clk);
      #1 bus.button = 1'b0;
      @(negedge clk);
      exp = ((k - 1) / Tick > MaxMs) ? 16'(MaxMs) : 16'((k - 1) / Tick);
      tests++;
      if (bus.reaction_time !== exp) begin
        fails++;
        $display("FAIL reaction_k%0d: got %0d, required %0d", k, bus.reaction_time, exp);
      end
      tests++;
      if (bus.led !== 1'b0) begin
        fails++;
        $display("FAIL led_off_after_press: got %b, required 0", bus.led);
      end
    end
  endtask

  task automatic test_reset();
    bus.button = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (bus.led !== 1'b0 || bus.reaction_time !== 16'd0 || bus.lcd_data !== 8'd0 ||
        bus.lcd_rs !== 1'b0 || bus.lcd_en !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: got led=%b rt=%h lcd=%h rs=%b en=%b, required all 0",
               bus.led, bus.reaction_time, bus.lcd_data, bus.lcd_rs, bus.lcd_en);
    end
    reset = 1'b1;
  endtask

`ifdef REACTION_LCD_EN
  task automatic wait_strobes(input int n);
    int t;
    t = 0;
    while (strobes.size() < n && t < 3000) begin
      @(posedge clk);
      t++;
    end
  endtask

  task automatic check_strobes(input logic [8:0] exp[5], input int n, input string name);
    logic [8:0] got;
    wait_strobes(n);
    for (int i = 0; i < n; i++) begin
      got = (i < strobes.size()) ? strobes[i] : 9'h1FF;
      tests++;
      if (got !== exp[i]) begin
        fails++;
        $display("FAIL %s_byte%0d: got rs/data %h, required %h", name, i, got, exp[i]);
      end
    end
  endtask

  task automatic test_lcd_init();
    logic [8:0] exp[5];
    exp = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h000};
    check_strobes(exp, 4, "lcd_init");
  endtask

  task automatic test_lcd();
    logic [8:0] exp[5];
    repeat (41 * LcdWait + 200) @(posedge clk);
    strobes.delete();
    run_reaction(371 + $urandom_range(0, 9));
    exp = '{9'h080, 9'h130, 9'h130, 9'h133, 9'h137};
    check_strobes(exp, 5, "lcd_37");
    repeat (LcdWait * 3) @(posedge clk);
    strobes.delete();
    press_btn();
    press_btn();
    exp = '{9'h080, 9'h145, 9'h172, 9'h172, 9'h121};
    check_strobes(exp, 5, "lcd_err");
  endtask
`else
  task automatic test_lcd_off();
    tests++;
    if (strobes.size() != 0 || bus.lcd_data !== 8'd0 || bus.lcd_rs !== 1'b0) begin
      fails++;
      $display("FAIL lcd_disabled: got %0d strobes data=%h rs=%b, required none/0/0",
               strobes.size(), bus.lcd_data, bus.lcd_rs);
    end
  endtask
`endif

  task automatic test_reaction();
    int unsigned ks[4];
    ks = '{4, Tick, Tick + 1, 2 * Tick};
    run_reaction(371 + $urandom_range(0, 9));
    foreach (ks[i]) run_reaction(ks[i]);
    for (int i = 0; i < 4; i++) run_reaction($urandom_range(4, 1200));
  endtask

  task automatic test_false_start();
    bit lit;
    lit = 1'b0;
    press_btn();
    repeat ($urandom_range(0, 15)) begin
      @(negedge clk);
      if (bus.led === 1'b1) lit = 1'b1;
    end
    press_btn();
    @(negedge clk);
    tests++;
    if (bus.reaction_time !== 16'hFFFF) begin
      fails++;
      $display("FAIL false_start_rt: got %h, required ffff", bus.reaction_time);
    end
    repeat (DlyHi + 50) begin
      @(negedge clk);
      if (bus.led === 1'b1) lit = 1'b1;
    end
    tests++;
    if (lit) begin
      fails++;
      $display("FAIL false_start_led: got led=1 during/after false start, required 0");
    end
  endtask

  task automatic test_timeout();
    int c, lit_cycles;
    bit ok;
    press_btn();
    wait_led(c, ok);
    lit_cycles = 0;
    while (ok && bus.led === 1'b1 && lit_cycles < int'(MaxMs * Tick + 100)) begin
      lit_cycles++;
      @(negedge clk);
    end
    tests++;
    if (lit_cycles < int'(MaxMs * Tick) || lit_cycles > int'(MaxMs * Tick + Tick)) begin
      fails++;
      $display("FAIL timeout_duration: got %0d lit cycles, required %0d..%0d", lit_cycles,
               MaxMs * Tick, MaxMs * Tick + Tick);
    end
    tests++;
    if (bus.reaction_time !== 16'(MaxMs)) begin
      fails++;
      $display("FAIL timeout_rt: got %0d, required %0d", bus.reaction_time, MaxMs);
    end
  endtask

  task automatic test_reset_mid_armed();
    int c;
    bit ok, lit;
    run_reaction(201);
    press_btn();
    wait_led(c, ok);
    repeat (50) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    tests++;
    if (bus.led !== 1'b0 || bus.reaction_time !== 16'd0) begin
      fails++;
      $display("FAIL async_reset: got led=%b rt=%h, required 0/0", bus.led, bus.reaction_time);
    end
    @(negedge clk);
    reset = 1'b1;
    lit = 1'b0;
    repeat (DlyHi + 100) begin
      @(negedge clk);
      if (bus.led === 1'b1) lit = 1'b1;
    end
    tests++;
    if (lit || bus.reaction_time !== 16'd0) begin
      fails++;
      $display("FAIL idle_after_reset: got led_seen=%b rt=%h, required 0/0", lit,
               bus.reaction_time);
    end
  endtask

  task automatic test_hold();
    int c;
    bit ok, changed;
    changed = 1'b0;
    @(posedge clk);
    #1 bus.button = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (bus.reaction_time !== 16'd0) changed = 1'b1;
    end
    tests++;
    if (changed) begin
      fails++;
      $display("FAIL hold_one_press: got rt=%h during hold, required 0", bus.reaction_time);
    end
    @(posedge clk);
    #1 bus.button = 1'b0;
    wait_led(c, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL hold_arms: got led=%b, required 1", bus.led);
    end
    press_btn();
    @(negedge clk);
    tests++;
    if (bus.reaction_time === 16'hFFFF || bus.led !== 1'b0) begin
      fails++;
      $display("FAIL hold_result: got rt=%h led=%b, required non-ffff/0", bus.reaction_time,
               bus.led);
    end
  endtask

  initial begin
    test_reset();
`ifdef REACTION_LCD_EN
    test_lcd_init();
`endif
    test_reaction();
    test_false_start();
    test_timeout();
    test_reset_mid_armed();
    test_hold();
`ifdef REACTION_LCD_EN
    test_lcd();
`else
    test_lcd_off();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
